// File: rtl/data_mem_pkg.sv
// Shared types for the data memory responder: FSM state, latched request and byte-lane helper.
package data_mem_pkg;

  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned REQ_WIDTH  = 32;
  localparam int unsigned NUM_LANES  = REQ_WIDTH / BYTE_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  typedef struct packed {
    logic [REQ_WIDTH-1:0] addr;
    logic                 we;
    logic                 byte_op;
    logic [REQ_WIDTH-1:0] wdata;
  } mem_req_t;

  // Word accesses enable every lane; byte accesses enable only the addressed lane.
  function automatic logic [NUM_LANES-1:0] lane_en(logic byte_op, logic [1:0] lane);
    return byte_op ? NUM_LANES'(1) << lane : {NUM_LANES{1'b1}};
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the data cache memory port and the responder.
// rsp_err exists only when DATA_MEM_ERR_EN is defined.
interface data_mem_responder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_addr;
  logic             req_we;
  logic             req_byte_op;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
`ifdef DATA_MEM_ERR_EN
  logic             rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_byte_op, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_addr, req_we, req_byte_op, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`else
  modport master (
    output req_valid, req_addr, req_we, req_byte_op, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_addr, req_we, req_byte_op, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
`endif
endinterface

// File: rtl/data_mem_array.sv
// Synchronous word array with per-byte write enables and registered read.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 10,
  parameter string       INIT_FILE = ""
) (
  input  logic                        clk_i,
  input  logic                        en_i,
  input  logic                        we_i,
  input  logic [WIDTH/BYTE_WIDTH-1:0] be_i,
  input  logic [ADDR_BITS-1:0]        addr_i,
  input  logic [WIDTH-1:0]            wdata_i,
  output logic [WIDTH-1:0]            rdata_o
);

  logic [WIDTH-1:0] mem_q [1 << ADDR_BITS];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < WIDTH / BYTE_WIDTH; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[b*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency memory responder for the data cache memory port (IDLE -> WAIT -> RESP).
// Define DATA_MEM_ERR_EN to flag misaligned word and out-of-range accesses on rsp_err.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned MEM_WORDS_LOG2 = 10,
  parameter int unsigned LATENCY        = 3,
  parameter string       INIT_FILE      = ""
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  data_mem_responder_if.slave bus_io
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "data_mem_responder: LATENCY must be within 1..15");
  end
  if (WIDTH != REQ_WIDTH) begin : g_bad_width
    $fatal(1, "data_mem_responder: WIDTH must be 32");
  end

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  mem_state_t       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  mem_req_t         req_q, req_d, acc_req, incoming;
  logic             access, acc_err, rsp_err;
  logic [WIDTH-1:0] arr_rdata, arr_wdata;

  assign incoming = '{addr:    bus_io.req_addr,
                      we:      bus_io.req_we,
                      byte_op: bus_io.req_byte_op,
                      wdata:   bus_io.req_wdata};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // The access fires on the edge that enters RESP; with LATENCY==1 that is the accept edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    access  = 1'b0;
    acc_req = req_q;
    unique case (state_q)
      IDLE: begin
        if (bus_io.req_valid) begin
          req_d = incoming;
          cnt_d = CntInit;
          if (LATENCY == 1) begin
            access  = 1'b1;
            acc_req = incoming;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus_io.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DATA_MEM_ERR_EN
  function automatic logic is_err(mem_req_t r);
    return (!r.byte_op && r.addr[1:0] != 2'b00) ||
           ((r.addr >> (MEM_WORDS_LOG2 + 2)) != '0);
  endfunction

  assign acc_err = is_err(acc_req);
  assign rsp_err = is_err(req_q);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_req.addr[REQ_WIDTH-1:MEM_WORDS_LOG2+2];
  assign acc_err        = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  assign arr_wdata = acc_req.byte_op ? {NUM_LANES{acc_req.wdata[BYTE_WIDTH-1:0]}}
                                     : acc_req.wdata;

  data_mem_array #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (MEM_WORDS_LOG2),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (access),
    .we_i    (acc_req.we && !acc_err),
    .be_i    (lane_en(acc_req.byte_op, acc_req.addr[1:0])),
    .addr_i  (acc_req.addr[MEM_WORDS_LOG2+1:2]),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  // The array read register is untouched until the next access, so RESP data stays stable.
  always_comb begin
    bus_io.req_ready = (state_q == IDLE);
    bus_io.rsp_valid = (state_q == RESP);
    bus_io.rsp_rdata = '0;
    if (state_q == RESP && !req_q.we && !rsp_err) begin
      bus_io.rsp_rdata = arr_rdata;
    end
`ifdef DATA_MEM_ERR_EN
    bus_io.rsp_err = (state_q == RESP) && rsp_err;
`endif
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=3 and a LATENCY=1 instance checked against a
// transaction-level model every cycle, plus directed literal expectations.
module tb_data_mem_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        v_req_valid[2], v_req_we[2], v_req_byte_op[2], v_rsp_ready[2];
  logic [31:0] v_req_addr[2], v_req_wdata[2];
  logic        o_req_ready[2], o_rsp_valid[2], o_rsp_err[2];
  logic [31:0] o_rsp_rdata[2];

  data_mem_responder_if #(.WIDTH(32)) bus3 ();
  data_mem_responder_if #(.WIDTH(32)) bus1 ();

  assign bus3.req_valid   = v_req_valid[0];
  assign bus3.req_addr    = v_req_addr[0];
  assign bus3.req_we      = v_req_we[0];
  assign bus3.req_byte_op = v_req_byte_op[0];
  assign bus3.req_wdata   = v_req_wdata[0];
  assign bus3.rsp_ready   = v_rsp_ready[0];
  assign o_req_ready[0]   = bus3.req_ready;
  assign o_rsp_valid[0]   = bus3.rsp_valid;
  assign o_rsp_rdata[0]   = bus3.rsp_rdata;
  assign bus1.req_valid   = v_req_valid[1];
  assign bus1.req_addr    = v_req_addr[1];
  assign bus1.req_we      = v_req_we[1];
  assign bus1.req_byte_op = v_req_byte_op[1];
  assign bus1.req_wdata   = v_req_wdata[1];
  assign bus1.rsp_ready   = v_rsp_ready[1];
  assign o_req_ready[1]   = bus1.req_ready;
  assign o_rsp_valid[1]   = bus1.rsp_valid;
  assign o_rsp_rdata[1]   = bus1.rsp_rdata;
`ifdef DATA_MEM_ERR_EN
  assign o_rsp_err[0] = bus3.rsp_err;
  assign o_rsp_err[1] = bus1.rsp_err;
`else
  assign o_rsp_err[0] = 1'b0;
  assign o_rsp_err[1] = 1'b0;
`endif

  data_mem_responder #(
    .WIDTH(32), .MEM_WORDS_LOG2(10), .LATENCY(3), .INIT_FILE("")
  ) u_dut3 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus3)
  );

  data_mem_responder #(
    .WIDTH(32), .MEM_WORDS_LOG2(10), .LATENCY(1), .INIT_FILE("")
  ) u_dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          cyc = 0;
  bit          m_pend[2], m_valid[2], m_err[2];
  int          m_due[2];
  logic [31:0] m_rdata[2], m_addr[2], m_wdata[2];
  logic        m_we[2], m_bop[2];
  logic [31:0] mmem[2][1024];

  function automatic int lat_of(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  task automatic model_access(input int i);
    logic [9:0]  idx;
    logic [31:0] w;
    bit          err;
    int          lane;
    idx  = m_addr[i][11:2];
    lane = int'(m_addr[i][1:0]);
`ifdef DATA_MEM_ERR_EN
    err = (!m_bop[i] && m_addr[i][1:0] != 2'b00) || (m_addr[i][31:12] != 20'h0);
`else
    err = 1'b0;
`endif
    if (m_we[i] && !err) begin
      w = m_bop[i] ? mmem[i][idx] : m_wdata[i];
      if (m_bop[i]) w[8*lane +: 8] = m_wdata[i][7:0];
      mmem[i][idx] = w;
    end
    m_rdata[i] = (m_we[i] || err) ? 32'h0 : mmem[i][idx];
    m_err[i]   = err;
    m_valid[i] = 1'b1;
  endtask

  // Response becomes visible LATENCY cycles after the accept cycle; reset drops it.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_pend[i]  = 1'b0;
        m_valid[i] = 1'b0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (m_valid[i]) begin
          if (v_rsp_ready[i]) begin
            m_valid[i] = 1'b0;
            m_pend[i]  = 1'b0;
          end
        end else if (!m_pend[i] && v_req_valid[i]) begin
          m_pend[i]  = 1'b1;
          m_addr[i]  = v_req_addr[i];
          m_we[i]    = v_req_we[i];
          m_bop[i]   = v_req_byte_op[i];
          m_wdata[i] = v_req_wdata[i];
          m_due[i]   = cyc + lat_of(i) - 1;
        end
        if (m_pend[i] && !m_valid[i] && cyc == m_due[i]) model_access(i);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.req_ready", i), o_req_ready[i], !m_pend[i]);
      chk($sformatf("u%0d.rsp_valid", i), o_rsp_valid[i], m_valid[i]);
      if (m_valid[i]) begin
        chk($sformatf("u%0d.rsp_rdata", i), o_rsp_rdata[i], m_rdata[i]);
`ifdef DATA_MEM_ERR_EN
        chk($sformatf("u%0d.rsp_err", i), o_rsp_err[i], m_err[i]);
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic txn(input int i, input logic [31:0] addr, input logic we, input logic bop,
                     input logic [31:0] wdata, output logic [31:0] rdata, output int lat,
                     output logic err);
    int n;
    @(negedge clk);
    v_req_valid[i]   = 1'b1;
    v_req_addr[i]    = addr;
    v_req_we[i]      = we;
    v_req_byte_op[i] = bop;
    v_req_wdata[i]   = wdata;
    n = 0;
    while (!o_req_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("txn accept", o_req_ready[i], 1'b1);
    @(posedge clk);
    @(negedge clk);
    v_req_valid[i] = 1'b0;
    lat = 1;
    while (!o_rsp_valid[i] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = o_rsp_rdata[i];
    err   = o_rsp_err[i];
  endtask

`ifdef DATA_MEM_ERR_EN
  localparam logic [31:0] ExpMis   = 32'h0;
  localparam logic [31:0] ExpAlias = 32'h0000A5A5;
`else
  localparam logic [31:0] ExpMis   = 32'hDEADBEEF;
  localparam logic [31:0] ExpAlias = 32'h00000001;
`endif

  initial begin
    logic [31:0] rd;
    int          lat, n;
    logic        er;
    for (int i = 0; i < 2; i++) begin
      v_req_valid[i] = 1'b0; v_req_we[i] = 1'b0; v_req_byte_op[i] = 1'b0;
      v_req_addr[i]  = '0;   v_req_wdata[i] = '0; v_rsp_ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("rst ready", o_req_ready[0], 1'b1);
    chk("rst valid", o_rsp_valid[0], 1'b0);
    chk("rst rdata", o_rsp_rdata[0], 32'h0);
    rst_n = 1'b1;

    txn(0, 32'h10, 1'b1, 1'b0, 32'hDEADBEEF, rd, lat, er);
    chk("wr lat", lat, 3);
    chk("wr rdata", rd, 32'h0);
    txn(0, 32'h10, 1'b0, 1'b0, 32'h0, rd, lat, er);
    chk("rd lat", lat, 3);
    chk("rd data", rd, 32'hDEADBEEF);

    txn(0, 32'h20, 1'b1, 1'b0, 32'h11223344, rd, lat, er);
    txn(0, 32'h22, 1'b1, 1'b1, 32'hFFFFFFAA, rd, lat, er);
    txn(0, 32'h20, 1'b0, 1'b0, 32'h0, rd, lat, er);
    chk("byte lane2", rd, 32'h11AA3344);
    txn(0, 32'h23, 1'b1, 1'b1, 32'h00000055, rd, lat, er);
    txn(0, 32'h21, 1'b0, 1'b1, 32'h0, rd, lat, er);
    chk("byte lane3", rd, 32'h55AA3344);

    // Stall the response and offer a competing write that must be ignored.
    txn(0, 32'h30, 1'b1, 1'b0, 32'h30303030, rd, lat, er);
    @(negedge clk);
    v_rsp_ready[0] = 1'b0;
    v_req_valid[0] = 1'b1; v_req_addr[0] = 32'h10; v_req_we[0] = 1'b0; v_req_byte_op[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v_req_we[0] = 1'b1; v_req_addr[0] = 32'h30; v_req_wdata[0] = 32'hBAD0BAD0;
    n = 0;
    while (!o_rsp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      chk("hold valid", o_rsp_valid[0], 1'b1);
      chk("hold rdata", o_rsp_rdata[0], 32'hDEADBEEF);
      chk("hold ready", o_req_ready[0], 1'b0);
      @(negedge clk);
    end
    v_rsp_ready[0] = 1'b1;
    @(negedge clk);
    v_req_valid[0] = 1'b0;
    chk("post hs ready", o_req_ready[0], 1'b1);
    chk("post hs valid", o_rsp_valid[0], 1'b0);
    txn(0, 32'h30, 1'b0, 1'b0, 32'h0, rd, lat, er);
    chk("ignored wr", rd, 32'h30303030);

    // Misaligned word read and high-address write (alias or error depending on build).
    txn(0, 32'h0, 1'b1, 1'b0, 32'h0000A5A5, rd, lat, er);
    txn(0, 32'h12, 1'b0, 1'b0, 32'h0, rd, lat, er);
    chk("misaligned rd", rd, ExpMis);
    chk("misaligned lat", lat, 3);
`ifdef DATA_MEM_ERR_EN
    chk("misaligned err", er, 1'b1);
`endif
    txn(0, 32'h10000, 1'b1, 1'b0, 32'h1, rd, lat, er);
`ifdef DATA_MEM_ERR_EN
    chk("oob err", er, 1'b1);
`endif
    chk("oob rdata", rd, 32'h0);
    txn(0, 32'h0, 1'b0, 1'b0, 32'h0, rd, lat, er);
    chk("alias rd", rd, ExpAlias);

    // LATENCY=1 instance: single-cycle responses, accepts every second cycle.
    txn(1, 32'h0, 1'b1, 1'b0, 32'hA0A0A0A0, rd, lat, er);
    chk("l1 wr lat", lat, 1);
    txn(1, 32'h4, 1'b1, 1'b0, 32'hB4B4B4B4, rd, lat, er);
    @(negedge clk);
    v_req_valid[1] = 1'b1; v_req_addr[1] = 32'h0; v_req_we[1] = 1'b0; v_req_byte_op[1] = 1'b0;
    chk("b2b ready0", o_req_ready[1], 1'b1);
    @(negedge clk);
    chk("b2b valid0", o_rsp_valid[1], 1'b1);
    chk("b2b data0", o_rsp_rdata[1], 32'hA0A0A0A0);
    chk("b2b busy", o_req_ready[1], 1'b0);
    v_req_addr[1] = 32'h4;
    @(negedge clk);
    chk("b2b ready1", o_req_ready[1], 1'b1);
    chk("b2b idle", o_rsp_valid[1], 1'b0);
    @(negedge clk);
    chk("b2b valid1", o_rsp_valid[1], 1'b1);
    chk("b2b data1", o_rsp_rdata[1], 32'hB4B4B4B4);
    v_req_valid[1] = 1'b0;

    // Reset while a write is still waiting: it must not reach the array.
    txn(0, 32'h40, 1'b1, 1'b0, 32'h12345678, rd, lat, er);
    @(negedge clk);
    v_req_valid[0] = 1'b1; v_req_addr[0] = 32'h40; v_req_we[0] = 1'b1;
    v_req_byte_op[0] = 1'b0; v_req_wdata[0] = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    v_req_valid[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async ready", o_req_ready[0], 1'b1);
    chk("async valid", o_rsp_valid[0], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    txn(0, 32'h40, 1'b0, 1'b0, 32'h0, rd, lat, er);
    chk("reset keeps old", rd, 32'h12345678);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
